bcd_timer_ctrl: RTL and testbench

- Controller that sequences two cascaded 2-digit BCD up/down counters (minutes, seconds) as an mm:ss countdown timer with alarm.
- Holds user-set shadow values edited by keys and loads them into the counters through their asynchronous load inputs.
- Drives count-enable from a 1 Hz tick, detects 00:00 and raises the alarm.
- Sits between the debounced key block and the counter instances; counter Q values feed back into this block.

---
 rtl/bcd_timer_ctrl_pkg.sv | 22 ++
 rtl/bcd_timer_ctrl_if.sv | 36 +++
 rtl/bcd_step.sv | 23 ++
 rtl/bcd_timer_ctrl.sv | 141 ++++++++++++++
 tb/tb_bcd_timer_ctrl.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_timer_ctrl_pkg.sv
// rtl/bcd_timer_ctrl_pkg.sv - shared state encoding and BCD constants for the mm:ss timer controller
// Purpose: state codes (also shown on state_o), BCD helper constants, default limits.
// Ports: none (package).
package timer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SET_MIN = 3'd1,
        ST_SET_SEC = 3'd2,
        ST_LOAD    = 3'd3,
        ST_RUN     = 3'd4,
        ST_PAUSE   = 3'd5,
        ST_ALARM   = 3'd6
    } state_t;

    localparam logic [7:0] ZERO8           = 8'h00;
    localparam logic [3:0] NINE            = 4'h9;
    localparam logic [7:0] SEC_MAX_DEF     = 8'h59;
    localparam logic [7:0] MIN_MAX_DEF     = 8'h99;
    localparam int         ALARM_TICKS_DEF = 10;

endpackage

// File: rtl/bcd_timer_ctrl_if.sv
// rtl/bcd_timer_ctrl_if.sv - key, tick and counter-side signal bundle of the timer controller
// Purpose: groups everything between the key/tick sources, the two BCD counters and the controller.
// Ports (slave = controller view):
//   in : tick, key_mode, key_inc, key_start, sec_q[7:0], min_q[7:0]
//   out: cnt_clr, cnt_pe, sec_d[7:0], min_d[7:0], sec_ce, min_ce,
//        sec_max[7:0], min_max[7:0], alarm, state_o[2:0]
interface bcd_timer_ctrl_if;
    logic       tick;
    logic       key_mode;
    logic       key_inc;
    logic       key_start;
    logic [7:0] sec_q;
    logic [7:0] min_q;
    logic       cnt_clr;
    logic       cnt_pe;
    logic [7:0] sec_d;
    logic [7:0] min_d;
    logic       sec_ce;
    logic       min_ce;
    logic [7:0] sec_max;
    logic [7:0] min_max;
    logic       alarm;
    logic [2:0] state_o;

    modport slave (
        input  tick, key_mode, key_inc, key_start, sec_q, min_q,
        output cnt_clr, cnt_pe, sec_d, min_d, sec_ce, min_ce,
               sec_max, min_max, alarm, state_o
    );

    modport master (
        output tick, key_mode, key_inc, key_start, sec_q, min_q,
        input  cnt_clr, cnt_pe, sec_d, min_d, sec_ce, min_ce,
               sec_max, min_max, alarm, state_o
    );
endinterface

// File: rtl/bcd_step.sv
// rtl/bcd_step.sv - combinational two-digit BCD increment with wrap at a given maximum
// Purpose: out = in + 1 in BCD; in == max wraps to 00.
// Ports: in[7:0] value, max[7:0] wrap point, out[7:0] result.
module bcd_step
    import timer_pkg::*;
(
    input  logic [7:0] in,
    input  logic [7:0] max,
    output logic [7:0] out
);

    always_comb begin
        out = ZERO8;
        if (in == max) begin
            out = ZERO8;
        end else if (in[3:0] == NINE) begin
            out = {in[7:4] + 4'd1, 4'd0};
        end else begin
            out = {in[7:4], in[3:0] + 4'd1};
        end
    end

endmodule

// File: rtl/bcd_timer_ctrl.sv
// rtl/bcd_timer_ctrl.sv - mm:ss countdown sequencer for two cascaded BCD down-counters with alarm
// Purpose: key-edited minute/second presets, counter load/clear pulses, tick-driven count
//          enables, 00:00 detection from counter Q and a tick-timed alarm.
// Ports: CP clock (rising), CR async active-high reset, bus (bcd_timer_ctrl_if.slave).
module bcd_timer_ctrl
    import timer_pkg::*;
#(
    parameter logic [7:0] SEC_MAX     = SEC_MAX_DEF,
    parameter logic [7:0] MIN_MAX     = MIN_MAX_DEF,
    parameter int         ALARM_TICKS = ALARM_TICKS_DEF
) (
    input  logic              CP,
    input  logic              CR,
    bcd_timer_ctrl_if.slave   bus
);

    localparam int             ACW        = $clog2(ALARM_TICKS + 1);
    localparam logic [ACW-1:0] ALARM_LAST = ACW'(ALARM_TICKS - 1);

    state_t         r_state;
    logic [7:0]     r_min_sh;
    logic [7:0]     r_sec_sh;
    logic [ACW-1:0] r_alarm_cnt;
    logic           r_alarm;
    logic           r_cnt_pe;
    logic           r_cnt_clr;

    logic [7:0]     w_min_inc;
    logic [7:0]     w_sec_inc;
    logic           w_any_key;
    logic           w_shadow_nz;
    logic           w_q_zero;
    logic           w_run_tick;

    bcd_step u_min_step (.in(r_min_sh), .max(MIN_MAX), .out(w_min_inc));
    bcd_step u_sec_step (.in(r_sec_sh), .max(SEC_MAX), .out(w_sec_inc));

    assign w_any_key   = bus.key_mode | bus.key_start | bus.key_inc;
    assign w_shadow_nz = (r_min_sh != ZERO8) || (r_sec_sh != ZERO8);
    assign w_q_zero    = ({bus.min_q, bus.sec_q} == {ZERO8, ZERO8});
    assign w_run_tick  = (r_state == ST_RUN) && bus.tick;

    // Enables come straight from the tick so the counters step on the same edge;
    // minutes borrow exactly when seconds is about to wrap 00 -> 59.
    assign bus.sec_ce  = w_run_tick && !w_q_zero;
    assign bus.min_ce  = w_run_tick && !w_q_zero && (bus.sec_q == ZERO8);

    assign bus.cnt_pe  = r_cnt_pe;
    assign bus.cnt_clr = r_cnt_clr;
    assign bus.sec_d   = r_sec_sh;
    assign bus.min_d   = r_min_sh;
    assign bus.sec_max = SEC_MAX;
    assign bus.min_max = MIN_MAX;
    assign bus.alarm   = r_alarm;
    assign bus.state_o = r_state;

    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            r_state     <= ST_IDLE;
            r_min_sh    <= ZERO8;
            r_sec_sh    <= ZERO8;
            r_alarm_cnt <= '0;
            r_alarm     <= 1'b0;
            r_cnt_pe    <= 1'b0;
            r_cnt_clr   <= 1'b0;
        end else begin
            // Both pulses are one cycle wide; they are only raised on distinct transitions,
            // so they can never coincide.
            r_cnt_pe  <= 1'b0;
            r_cnt_clr <= 1'b0;

            case (r_state)
                ST_IDLE, ST_SET_MIN, ST_SET_SEC: begin
                    if (bus.key_mode) begin
                        if (r_state == ST_IDLE) begin
                            r_state <= ST_SET_MIN;
                        end else if (r_state == ST_SET_MIN) begin
                            r_state <= ST_SET_SEC;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else if (bus.key_start) begin
                        // A 00:00 preset would alarm immediately; ignore the start instead.
                        if (w_shadow_nz) begin
                            r_state  <= ST_LOAD;
                            r_cnt_pe <= 1'b1;
                        end
                    end else if (bus.key_inc) begin
                        if (r_state == ST_SET_MIN) begin
                            r_min_sh <= w_min_inc;
                        end else if (r_state == ST_SET_SEC) begin
                            r_sec_sh <= w_sec_inc;
                        end
                    end
                end

                ST_LOAD: begin
                    r_state <= ST_RUN;
                end

                ST_RUN: begin
                    if (bus.key_mode) begin
                        r_state   <= ST_IDLE;
                        r_cnt_clr <= 1'b1;
                    end else if (bus.key_start) begin
                        r_state <= ST_PAUSE;
                    end else if (bus.tick && w_q_zero) begin
                        r_state     <= ST_ALARM;
                        r_alarm     <= 1'b1;
                        r_alarm_cnt <= '0;
                    end
                end

                ST_PAUSE: begin
                    if (bus.key_mode) begin
                        r_state   <= ST_IDLE;
                        r_cnt_clr <= 1'b1;
                    end else if (bus.key_start) begin
                        r_state <= ST_RUN;
                    end
                end

                ST_ALARM: begin
                    if (w_any_key || (bus.tick && (r_alarm_cnt == ALARM_LAST))) begin
                        r_state     <= ST_IDLE;
                        r_alarm     <= 1'b0;
                        r_alarm_cnt <= '0;
                        r_cnt_clr   <= 1'b1;
                    end else if (bus.tick) begin
                        r_alarm_cnt <= r_alarm_cnt + ACW'(1);
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// tb/tb_bcd_timer_ctrl.sv - self-checking bench for bcd_timer_ctrl against a decimal reference model
module tb_bcd_timer_ctrl;

    logic CP = 1'b0;
    logic CR = 1'b0;

    bcd_timer_ctrl_if bus ();

    bcd_timer_ctrl dut (
        .CP  (CP),
        .CR  (CR),
        .bus (bus)
    );

    always #5 CP = ~CP;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: presets and counter values kept as plain decimal integers.
    int m_state;
    int m_min;
    int m_sec;
    int m_acnt;
    bit m_alarm;
    bit m_pe;
    bit m_clr;
    int q_min;
    int q_sec;

    function automatic logic [7:0] bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive_q();
        bus.min_q = bcd(q_min);
        bus.sec_q = bcd(q_sec);
    endtask

    task automatic model_reset();
        m_state = 0;
        m_min   = 0;
        m_sec   = 0;
        m_acnt  = 0;
        m_alarm = 1'b0;
        m_pe    = 1'b0;
        m_clr   = 1'b0;
    endtask

    task automatic model_abort();
        m_state = 0;
        m_clr   = 1'b1;
        m_alarm = 1'b0;
        m_acnt  = 0;
    endtask

    task automatic model_step(input bit t, input bit m, input bit i, input bit s);
        int total;
        total = q_min * 60 + q_sec;
        m_pe  = 1'b0;
        m_clr = 1'b0;
        case (m_state)
            0, 1, 2: begin
                if (m) begin
                    m_state = (m_state + 1) % 3;
                end else if (s) begin
                    if (m_min != 0 || m_sec != 0) begin
                        m_state = 3;
                        m_pe    = 1'b1;
                    end
                end else if (i) begin
                    if (m_state == 1) m_min = (m_min + 1) % 100;
                    if (m_state == 2) m_sec = (m_sec + 1) % 60;
                end
            end
            3: m_state = 4;
            4: begin
                if (m) model_abort();
                else if (s) m_state = 5;
                else if (t && total == 0) begin
                    m_state = 6;
                    m_alarm = 1'b1;
                    m_acnt  = 0;
                end
            end
            5: begin
                if (m) model_abort();
                else if (s) m_state = 4;
            end
            6: begin
                if (m || i || s) model_abort();
                else if (t) begin
                    m_acnt++;
                    if (m_acnt == 10) model_abort();
                end
            end
            default: ;
        endcase
    endtask

    task automatic chk_regs();
        chk("state_o", 16'(bus.state_o), 16'(m_state));
        chk("alarm", 16'(bus.alarm), 16'(m_alarm));
        chk("cnt_pe", 16'(bus.cnt_pe), 16'(m_pe));
        chk("cnt_clr", 16'(bus.cnt_clr), 16'(m_clr));
        chk("sec_d", 16'(bus.sec_d), 16'(bcd(m_sec)));
        chk("min_d", 16'(bus.min_d), 16'(bcd(m_min)));
        chk("pe_clr_excl", 16'(bus.cnt_pe & bus.cnt_clr), 16'h0000);
        chk("sec_max", 16'(bus.sec_max), 16'h0059);
        chk("min_max", 16'(bus.min_max), 16'h0099);
    endtask

    // Called at posedge+1: drive one cycle of inputs, check enables, step the edge, check state.
    task automatic cyc(input bit t, input bit m, input bit i, input bit s);
        bit run_t;
        int total;
        bus.tick      = t;
        bus.key_mode  = m;
        bus.key_inc   = i;
        bus.key_start = s;
        drive_q();
        #1;
        run_t = (m_state == 4) && t;
        total = q_min * 60 + q_sec;
        chk("sec_ce", 16'(bus.sec_ce), 16'(run_t && total != 0));
        chk("min_ce", 16'(bus.min_ce), 16'(run_t && total != 0 && q_sec == 0));
        @(posedge CP);
        #1;
        model_step(t, m, i, s);
        bus.tick      = 1'b0;
        bus.key_mode  = 1'b0;
        bus.key_inc   = 1'b0;
        bus.key_start = 1'b0;
        chk_regs();
    endtask

    // Asynchronous reset between edges, checked before any clock edge arrives.
    task automatic do_reset();
        #2;
        bus.tick = 1'b1;
        CR = 1'b1;
        #1;
        model_reset();
        chk_regs();
        chk("sec_ce_rst", 16'(bus.sec_ce), 16'h0000);
        chk("min_ce_rst", 16'(bus.min_ce), 16'h0000);
        bus.tick = 1'b0;
        @(posedge CP);
        #1;
        CR = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.tick      = 1'b0;
        bus.key_mode  = 1'b0;
        bus.key_inc   = 1'b0;
        bus.key_start = 1'b0;
        q_min = 0;
        q_sec = 0;
        drive_q();
        model_reset();
        #1 CR = 1'b1;
        #2 chk_regs();
        @(posedge CP);
        #1 CR = 1'b0;

        // Shadow wrap behaviour
        cyc(0, 1, 0, 0);
        repeat (9) cyc(0, 0, 1, 0);
        chk("min_sh_09", 16'(bus.min_d), 16'h0009);
        cyc(0, 0, 1, 0);
        chk("min_sh_10", 16'(bus.min_d), 16'h0010);
        repeat (89) cyc(0, 0, 1, 0);
        chk("min_sh_99", 16'(bus.min_d), 16'h0099);
        cyc(0, 0, 1, 0);
        chk("min_sh_wrap", 16'(bus.min_d), 16'h0000);
        cyc(0, 1, 0, 0);
        repeat (59) cyc(0, 0, 1, 0);
        chk("sec_sh_59", 16'(bus.sec_d), 16'h0059);
        cyc(0, 0, 1, 0);
        chk("sec_sh_wrap", 16'(bus.sec_d), 16'h0000);
        cyc(0, 1, 1, 0);
        chk("prio_mode_inc", 16'(bus.state_o), 16'h0000);

        // Preset 03:02 and load
        do_reset();
        cyc(0, 1, 0, 0);
        repeat (3) cyc(0, 0, 1, 0);
        cyc(0, 1, 0, 0);
        repeat (2) cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 1);
        chk("load_pe", 16'(bus.cnt_pe), 16'h0001);
        chk("load_min_d", 16'(bus.min_d), 16'h0003);
        chk("load_sec_d", 16'(bus.sec_d), 16'h0002);
        cyc(1, 0, 0, 0);
        chk("run_after_load", 16'(bus.state_o), 16'h0004);

        // Borrow / no borrow
        q_min = 1; q_sec = 0;
        cyc(1, 0, 0, 0);
        q_sec = 30;
        cyc(1, 0, 0, 0);

        // Pause / resume / abort with tick in the same cycle
        cyc(0, 0, 0, 1);
        repeat (3) cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 1);
        q_min = 2; q_sec = 15;
        cyc(1, 1, 0, 0);
        chk("abort_clr", 16'(bus.cnt_clr), 16'h0001);

        // Reach 00:00 and let the alarm time out
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        q_min = 0; q_sec = 0;
        cyc(1, 0, 0, 0);
        chk("alarm_on", 16'(bus.alarm), 16'h0001);
        for (int k = 0; k < 10; k++) begin
            q_min = $urandom_range(0, 1);
            q_sec = $urandom_range(0, 59);
            cyc(0, 0, 0, 0);
            cyc(1, 0, 0, 0);
        end
        chk("alarm_off", 16'(bus.alarm), 16'h0000);
        chk("alarm_clr", 16'(bus.cnt_clr), 16'h0001);

        // Zero preset start ignored, then reset mid-run
        do_reset();
        cyc(0, 0, 0, 1);
        chk("zero_start_pe", 16'(bus.cnt_pe), 16'h0000);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        q_min = 0; q_sec = 45;
        cyc(1, 0, 0, 0);
        do_reset();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            int r;
            bit t;
            r = $urandom_range(0, 15);
            t = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) begin
                q_min = 0;
                q_sec = 0;
            end else begin
                q_min = $urandom_range(0, 2);
                q_sec = $urandom_range(0, 59);
            end
            cyc(t, (r == 0) || (r == 4), (r == 2) || (r == 3) || (r == 4), (r == 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
